// File: rtl/btn_pkg.sv
// Shared types and 50 MHz default timing constants for the button conditioner.
package btn_pkg;
  typedef enum logic [1:0] {IDLE, DEB_PRESS, HELD, DEB_RELEASE} btn_state_e;

  localparam int DEF_DEB_CYCLES    = 500_000;     // 10 ms
  localparam int DEF_LONG_CYCLES   = 50_000_000;  // 1 s
  localparam int DEF_REPEAT_CYCLES = 12_500_000;  // 250 ms
endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, debounce FSM, long-press and auto-repeat timing.
// Auto-repeat is built only when BTN_REPEAT_EN is defined.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES);

  if (DEB_CYCLES < 2 || LONG_CYCLES <= DEB_CYCLES || REPEAT_CYCLES < 2) begin : g_param_check
    $error("btn_debounce: illegal timing parameters");
  end

  btn_state_e      r_state;
  logic [1:0]      r_sync;
  logic [DW-1:0]   r_deb_cnt;
  logic [HW-1:0]   r_hold_cnt;
  logic            r_long_done;
  logic            r_pressed;
  logic            r_press;
  logic            r_release;
  logic            r_long;
  logic            w_sync;

  assign w_sync = r_sync[1];

`ifdef BTN_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  logic [RW-1:0] r_rep_cnt;
  logic          r_repeat;
  assign repeat_pulse = r_repeat;
`else
  assign repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_sync      <= 2'b11;
      r_deb_cnt   <= '0;
      r_hold_cnt  <= '0;
      r_long_done <= 1'b0;
      r_pressed   <= 1'b0;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_long      <= 1'b0;
`ifdef BTN_REPEAT_EN
      r_rep_cnt   <= '0;
      r_repeat    <= 1'b0;
`endif
    end else begin
      r_sync    <= {r_sync[0], btn_n};
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
`ifdef BTN_REPEAT_EN
      r_repeat  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (!w_sync) begin
            r_state   <= DEB_PRESS;
            r_deb_cnt <= '0;
          end
        end
        DEB_PRESS: begin
          if (w_sync) begin
            r_state <= IDLE;
          end else if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
            r_state     <= HELD;
            r_pressed   <= 1'b1;
            r_press     <= 1'b1;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
`ifdef BTN_REPEAT_EN
            r_rep_cnt   <= '0;
`endif
          end else begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
          end
        end
        HELD: begin
          // Saturated count plus a done flag makes the long event exactly LONG_CYCLES after press.
          if (r_hold_cnt != HW'(LONG_CYCLES - 1)) begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end else if (!r_long_done) begin
            r_long      <= 1'b1;
            r_long_done <= 1'b1;
          end
`ifdef BTN_REPEAT_EN
          if (r_long_done) begin
            if (r_rep_cnt == RW'(REPEAT_CYCLES - 1)) begin
              r_rep_cnt <= '0;
              r_repeat  <= 1'b1;
            end else begin
              r_rep_cnt <= r_rep_cnt + RW'(1);
            end
          end
`endif
          if (w_sync) begin
            r_state   <= DEB_RELEASE;
            r_deb_cnt <= '0;
          end
        end
        DEB_RELEASE: begin
          if (!w_sync) begin
            r_state <= HELD;
          end else if (r_deb_cnt == DW'(DEB_CYCLES - 1)) begin
            r_state   <= IDLE;
            r_pressed <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;
endmodule

// File: rtl/btn_input.sv
// Conditions NBTN raw active-low buttons into held levels and single-cycle events.
// Define BTN_REPEAT_EN to build the auto-repeat pulses.
module btn_input
  import btn_pkg::*;
#(
  parameter int NBTN          = 2,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_n,
  output logic [NBTN-1:0] pressed,
  output logic [NBTN-1:0] press_pulse,
  output logic [NBTN-1:0] release_pulse,
  output logic [NBTN-1:0] long_pulse,
  output logic [NBTN-1:0] repeat_pulse
);
  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_deb (
      .clk          (clk),
      .reset        (reset),
      .btn_n        (btn_n[i]),
      .pressed      (pressed[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i])
    );
  end
endmodule

// File: tb/tb_btn_input.sv
// Bench for btn_input: run-length behavioural model checked every cycle, plus directed timing checks.
module tb_btn_input;
  localparam int NBTN = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 5;
`ifdef BTN_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NBTN-1:0] btn_n = '1;
  logic [NBTN-1:0] pressed, press_pulse, release_pulse, long_pulse, repeat_pulse;

  btn_input #(
    .NBTN(NBTN), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n),
    .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: a level flips after DEB+1 consecutive synchronised samples disagree with it;
  // hold time is the number of edges spent pressed with no release run pending.
  bit s1[NBTN], s2[NBTN], lvl[NBTN];
  int run[NBTN], held[NBTN];
  logic [NBTN-1:0] e_pressed, e_press, e_rel, e_long, e_rep;

  int press_q[NBTN][$];
  int rel_q[NBTN][$];
  int long_q[NBTN][$];
  int rep_q[NBTN][$];
  logic [NBTN-1:0] last_press_vec = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NBTN; b++) begin
      s1[b] = 1'b1; s2[b] = 1'b1; lvl[b] = 1'b0; run[b] = 0; held[b] = 0;
    end
    e_pressed = '0; e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
  endtask

  task automatic model_step();
    for (int b = 0; b < NBTN; b++) begin
      bit smp_rel;
      smp_rel = s2[b];
      s2[b] = s1[b];
      s1[b] = btn_n[b];
      e_press[b] = 1'b0; e_rel[b] = 1'b0; e_long[b] = 1'b0; e_rep[b] = 1'b0;
      if (!lvl[b]) begin
        run[b] = smp_rel ? 0 : run[b] + 1;
        if (run[b] == DEB + 1) begin
          lvl[b] = 1'b1; e_press[b] = 1'b1; run[b] = 0; held[b] = 0;
        end
      end else begin
        if (run[b] == 0) begin
          held[b]++;
          if (held[b] == LONG) e_long[b] = 1'b1;
          if (REP_EN && held[b] > LONG && ((held[b] - LONG) % REP) == 0) e_rep[b] = 1'b1;
        end
        run[b] = smp_rel ? run[b] + 1 : 0;
        if (run[b] == DEB + 1) begin
          lvl[b] = 1'b0; e_rel[b] = 1'b1; run[b] = 0;
        end
      end
      e_pressed[b] = lvl[b];
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) model_reset();
      else model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("pressed", 32'(pressed), 32'(e_pressed));
      chk("press_pulse", 32'(press_pulse), 32'(e_press));
      chk("release_pulse", 32'(release_pulse), 32'(e_rel));
      chk("long_pulse", 32'(long_pulse), 32'(e_long));
      chk("repeat_pulse", 32'(repeat_pulse), 32'(e_rep));
      if (press_pulse != '0) last_press_vec = press_pulse;
      for (int b = 0; b < NBTN; b++) begin
        if (press_pulse[b] === 1'b1)   press_q[b].push_back(cyc);
        if (release_pulse[b] === 1'b1) rel_q[b].push_back(cyc);
        if (long_pulse[b] === 1'b1)    long_q[b].push_back(cyc);
        if (repeat_pulse[b] === 1'b1)  rep_q[b].push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    for (int b = 0; b < NBTN; b++) begin
      press_q[b].delete(); rel_q[b].delete(); long_q[b].delete(); rep_q[b].delete();
    end
    last_press_vec = '0;
  endtask

  function automatic int first_or(input int q[$], input int idx);
    return (q.size() > idx) ? q[idx] : -1000;
  endfunction

  int e0, r0, p0, l0, n1;
  int dur[NBTN];

  initial begin
    repeat (3) tick();
    chk("reset_pressed", 32'(pressed), 0);
    chk("reset_press", 32'(press_pulse), 0);
    chk("reset_release", 32'(release_pulse), 0);
    chk("reset_long", 32'(long_pulse), 0);
    chk("reset_repeat", 32'(repeat_pulse), 0);
    reset = 1'b0;
    repeat (5) tick();

    // Clean press on button 0, held 40 cycles past the press event, then released.
    clear_logs();
    e0 = cyc + 1;
    btn_n[0] = 1'b0;
    repeat (46) tick();
    p0 = first_or(press_q[0], 0);
    l0 = first_or(long_q[0], 0);
    chk("press_latency", 32'(p0 - e0), 6);
    chk("press_count", 32'(press_q[0].size()), 1);
    chk("pressed_after_press", 32'(pressed[0]), 1);
    chk("long_after_press", 32'(l0 - p0), 20);
    chk("long_count", 32'(long_q[0].size()), 1);
`ifdef BTN_REPEAT_EN
    chk("repeat1", 32'(first_or(rep_q[0], 0) - l0), 5);
    chk("repeat2", 32'(first_or(rep_q[0], 1) - l0), 10);
    chk("repeat3", 32'(first_or(rep_q[0], 2) - l0), 15);
`else
    chk("repeat_absent", 32'(rep_q[0].size()), 0);
`endif
    r0 = cyc + 1;
    btn_n[0] = 1'b1;
    repeat (15) tick();
    chk("release_latency", 32'(first_or(rel_q[0], 0) - r0), 6);
    chk("pressed_after_release", 32'(pressed[0]), 0);
    n1 = press_q[1].size() + rel_q[1].size() + long_q[1].size() + rep_q[1].size();
    chk("btn1_quiet", 32'(n1), 0);

    // Bounce on button 1: every low run is shorter than the debounce window.
    clear_logs();
    for (int k = 0; k < 5; k++) begin
      btn_n[1] = 1'b0; repeat (3) tick();
      btn_n[1] = 1'b1; repeat (2) tick();
    end
    repeat (10) tick();
    n1 = press_q[1].size() + rel_q[1].size() + long_q[1].size() + rep_q[1].size();
    chk("bounce_no_events", 32'(n1), 0);
    chk("bounce_pressed", 32'(pressed[1]), 0);

    // Reset while held: outputs clear at once, press re-detected after release of reset.
    btn_n[0] = 1'b0;
    repeat (15) tick();
    chk("held_before_reset", 32'(pressed[0]), 1);
    reset = 1'b1;
    #1;
    chk("reset_async_pressed", 32'(pressed), 0);
    chk("reset_async_pulses", 32'({press_pulse, release_pulse, long_pulse, repeat_pulse}), 0);
    repeat (2) tick();
    clear_logs();
    reset = 1'b0;
    e0 = cyc + 1;
    repeat (12) tick();
    chk("repress_latency", 32'(first_or(press_q[0], 0) - e0), 6);
    chk("repress_no_release", 32'(rel_q[0].size()), 0);
    btn_n[0] = 1'b1;
    repeat (15) tick();

    // Simultaneous press on both buttons.
    clear_logs();
    e0 = cyc + 1;
    btn_n = 2'b00;
    repeat (10) tick();
    chk("both_press_vec", 32'(last_press_vec), 32'h3);
    chk("both_press_time0", 32'(first_or(press_q[0], 0) - e0), 6);
    chk("both_press_time1", 32'(first_or(press_q[1], 0) - e0), 6);
    btn_n = 2'b11;
    repeat (15) tick();

    // Randomised bounce/hold patterns with occasional resets; the per-cycle compare judges them.
    for (int b = 0; b < NBTN; b++) dur[b] = 1;
    for (int t = 0; t < 4000; t++) begin
      for (int b = 0; b < NBTN; b++) begin
        dur[b]--;
        if (dur[b] <= 0) begin
          btn_n[b] = ~btn_n[b];
          dur[b] = ($urandom_range(0, 2) == 0) ? $urandom_range(1, DEB + 2)
                                               : $urandom_range(DEB + 2, 70);
        end
      end
      if ($urandom_range(0, 999) == 0) begin
        reset = 1'b1; tick(); tick(); reset = 1'b0;
      end
      tick();
    end
    btn_n = '1;
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/btn_input.md
# btn_input

Button input conditioner for the LED-pattern designs: synchronises and debounces the board's raw active-low push buttons. Produces a clean held level plus single-cycle press, release, long-press and (optional) auto-repeat events. Sits between the board button pins and the pattern/speed control logic, which consumes only the event pulses and never samples raw pins.

## Interface
- NBTN, 2: number of independent buttons.
- DEB_CYCLES, 500_000: stable-sample count to accept a level change (10 ms at 50 MHz); must be ≥ 2.
- LONG_CYCLES, 50_000_000: hold duration after the press event before the long-press event; must be > DEB_CYCLES.
- REPEAT_CYCLES, 12_500_000: auto-repeat period after the long press; must be ≥ 2.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- btn_n  in  NBTN  raw button pins, active-low, asynchronous to clk.
- pressed  out  NBTN  debounced level; 1 = button held.
- press_pulse  out  NBTN  one-cycle pulse on accepted press.
- release_pulse  out  NBTN  one-cycle pulse on accepted release.
- long_pulse  out  NBTN  one-cycle pulse, once per press, at long-press threshold.
- repeat_pulse  out  NBTN  one-cycle auto-repeat pulses; constant 0 when the feature is compiled out.

## Operation
- Per button: 2-flop synchroniser (reset value 1 = released), then FSM with states IDLE, DEB_PRESS, HELD, DEB_RELEASE.
- Counters: deb_cnt, hold_cnt, rep_cnt. Widths are $clog2 of the respective parameter; all counters are unsigned and must never wrap.
- IDLE: sync = 0 → DEB_PRESS, deb_cnt ← 0.
- DEB_PRESS: sync = 1 → IDLE with no event (bounce rejected). Otherwise deb_cnt increments. When deb_cnt = DEB_CYCLES−1 with sync = 0:
  - → HELD.
  - pressed ← 1; press_pulse ← 1; hold_cnt ← 0; rep_cnt ← 0.
- HELD:
  - hold_cnt increments and saturates at LONG_CYCLES−1.
  - On the cycle hold_cnt reaches LONG_CYCLES−1, long_pulse ← 1. It fires only once per press.
  - sync = 1 → DEB_RELEASE, deb_cnt ← 0.
- DEB_RELEASE:
  - hold_cnt and rep_cnt freeze.
  - sync = 0 → HELD with no event; counts resume.
  - When deb_cnt = DEB_CYCLES−1 with sync = 1: → IDLE, pressed ← 0, release_pulse ← 1.
- Buttons are fully independent. Simultaneous presses each produce their own pulses in the same cycle.
- All outputs are registered. At most one of press/release/long pulses is asserted per button per cycle.
- Reset (any time, including mid-debounce or mid-hold):
  - All FSMs → IDLE; all counters 0; synchronisers 1.
  - pressed, press_pulse, release_pulse, long_pulse, repeat_pulse all 0.
  - A button still held at deassertion is detected as a fresh press after full latency.

## Timing
- Raw falling edge set up before edge 0: synchroniser output low after edge 1; IDLE→DEB_PRESS at edge 2; press_pulse high for the cycle following edge 2+DEB_CYCLES.
- Release latency is identical: release_pulse high after edge 2+DEB_CYCLES relative to a clean raw rising edge.
- long_pulse is LONG_CYCLES cycles after press_pulse, provided no release debounce intervened. Time spent in DEB_RELEASE extends this by its duration.
- Any bounce shorter than DEB_CYCLES consecutive samples produces no event.

## Configuration
- BTN_REPEAT_EN defined:
  - In HELD after long_pulse, rep_cnt counts 0..REPEAT_CYCLES−1 and wraps.
  - repeat_pulse asserts on each wrap, so the first repeat occurs REPEAT_CYCLES after long_pulse.
  - Stops on entry to DEB_RELEASE; rep_cnt clears on the next press.
- BTN_REPEAT_EN undefined: rep_cnt and repeat logic are absent; repeat_pulse tied to 0.

## Structure
- Package btn_pkg: state enum btn_state_e {IDLE, DEB_PRESS, HELD, DEB_RELEASE}; default constants for DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES at 50 MHz.
- Sub-module btn_debounce: synchroniser, FSM and counters for one button. btn_input generates NBTN instances and concatenates their outputs.

## Test plan
Simulation parameters: DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5.
- Clean press on btn_n[0]: held low → press_pulse[0] exactly one cycle, 6 edges after the fall; pressed[0]=1; no events on button 1.
- Bounce: btn_n[1] low 3 cycles / high 2, repeated 5×, then high → no pulses; pressed[1] stays 0.
- Hold 40 cycles then release: long_pulse once, 20 cycles after press_pulse; release_pulse 6 edges after the rise; pressed returns to 0.
- With BTN_REPEAT_EN, hold 40 cycles: repeat_pulse at long_pulse+5, +10, +15. Without the macro: repeat_pulse constantly 0.
- Reset asserted mid-HELD with button held → all outputs 0 immediately. After deassertion: press_pulse again after 6 edges; no release_pulse is emitted.
- Both buttons pressed on the same edge → press_pulse = 2'b11 in the same single cycle.
